// File: rtl/rcn_fifo_pkg.sv
// rtl/rcn_fifo_pkg.sv - Gray-code helpers shared by the rcn async FIFO
// Functions work on the widest pointer (9 bits); narrower pointers are zero-extended.
package rcn_fifo_pkg;

  localparam int PTR_MAX_W = 9;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  function automatic ptr_max_t bin2gray(input ptr_max_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero upper bits stay zero, so the low bits are correct for any narrower pointer.
  function automatic ptr_max_t gray2bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/rcn_sync_2ff.sv
// rtl/rcn_sync_2ff.sv - two-flop synchronizer for a Gray-coded bus
module rcn_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rcn_fifo_async.sv
// rtl/rcn_fifo_async.sv - parametrised async FIFO, Gray pointer crossing, levels and sticky errors
module rcn_fifo_async
  import rcn_fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_LEVEL   = (1 << DEPTH_LOG2) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  rst_in,
  input  logic                  clk_in,
  input  logic                  clk_out,
  input  logic [WIDTH-1:0]      din,
  input  logic                  push,
  output logic                  full,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   wr_level,
  output logic                  overflow,
  output logic [WIDTH-1:0]      dout,
  input  logic                  pop,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   rd_level,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t AF_P    = ptr_t'(AF_LEVEL);
  localparam ptr_t AE_P    = ptr_t'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  ptr_t     wr_ptr_q, wr_ptr_d, wr_gray_q, wr_gray_d;
  ptr_t     rd_gray_sync, rd_ptr_sync;
  logic     overflow_q, overflow_d;
  logic     push_ok;
  ptr_max_t wr_gray_ext, rd_bin_ext;

  ptr_t     rd_ptr_q, rd_ptr_d, rd_gray_q, rd_gray_d;
  ptr_t     wr_gray_sync, wr_ptr_sync;
  logic     underflow_q, underflow_d;
  logic     pop_ok;
  ptr_max_t rd_gray_ext, wr_bin_ext;

  // Upper bits of the widened conversions are always zero and deliberately dropped.
  logic unused_ext;
  assign unused_ext = ^{wr_gray_ext, rd_bin_ext, rd_gray_ext, wr_bin_ext};

  // ---------------- write domain ----------------
  assign wr_level    = wr_ptr_q - rd_ptr_sync;
  assign full        = (wr_level == DEPTH_P);
  assign almost_full = (wr_level >= AF_P);
  assign overflow    = overflow_q;
  assign push_ok     = push && !full;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end else if (push) begin
      overflow_d = 1'b1;
    end
  end

  assign wr_gray_ext = bin2gray(ptr_max_t'(wr_ptr_d));
  assign wr_gray_d   = wr_gray_ext[PW-1:0];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q   <= '0;
      wr_gray_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      wr_gray_q  <= wr_gray_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
    end
  end

  rcn_sync_2ff #(.WIDTH(PW)) u_sync_rd2wr (
    .clk_i (clk_in),
    .rst_i (rst_in),
    .d_i   (rd_gray_q),
    .q_o   (rd_gray_sync)
  );

  assign rd_bin_ext  = gray2bin(ptr_max_t'(rd_gray_sync));
  assign rd_ptr_sync = rd_bin_ext[PW-1:0];

  // ---------------- read domain ----------------
  assign rd_level     = wr_ptr_sync - rd_ptr_q;
  assign empty        = (rd_ptr_q == wr_ptr_sync);
  assign almost_empty = (rd_level <= AE_P);
  assign underflow    = underflow_q;
  assign pop_ok       = pop && !empty;
  assign dout         = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    underflow_d = underflow_q;
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end else if (pop) begin
      underflow_d = 1'b1;
    end
  end

  assign rd_gray_ext = bin2gray(ptr_max_t'(rd_ptr_d));
  assign rd_gray_d   = rd_gray_ext[PW-1:0];

  always_ff @(posedge clk_out or posedge rst_in) begin
    if (rst_in) begin
      rd_ptr_q    <= '0;
      rd_gray_q   <= '0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      rd_gray_q   <= rd_gray_d;
      underflow_q <= underflow_d;
    end
  end

  rcn_sync_2ff #(.WIDTH(PW)) u_sync_wr2rd (
    .clk_i (clk_out),
    .rst_i (rst_in),
    .d_i   (wr_gray_q),
    .q_o   (wr_gray_sync)
  );

  assign wr_bin_ext  = gray2bin(ptr_max_t'(wr_gray_sync));
  assign wr_ptr_sync = wr_bin_ext[PW-1:0];

endmodule
